// File: rtl/rhs_pkt_pkg.sv
// Shared constants and types for the RHS sample packetizer.
// Imported by the FIFO, the top level and the bench.
package rhs_pkt_pkg;

  localparam logic [63:0] MAGIC_DEFAULT = 64'hD7A22AAA38132A53;
  localparam int NUM_CH_DEFAULT = 32;
  localparam int HDR_WORDS = 2;

  typedef enum logic [1:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA
  } pkt_state_e;

endpackage

// File: rtl/rhs_pkt_fifo.sv
// Single-clock sample FIFO whose write pointer can be rolled back
// to a saved frame start, so a broken frame never becomes visible.
module rhs_pkt_fifo
  import rhs_pkt_pkg::*;
#(
  parameter int DW = 32,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  input  logic          rb_en,
  input  logic [AW:0]   rb_ptr,
  output logic [AW:0]   wr_ptr,
  output logic [AW:0]   free
);

  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   wr_base;

  // Free space is judged after any rollback in the same cycle.
  always_comb begin
    wr_base  = rb_en ? rb_ptr : wr_ptr_q;
    wr_ptr_d = wr_en ? wr_base + PTR_ONE : wr_base;
    rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    free     = DEPTH_W - (wr_base - rd_ptr_q);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_base[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_ptr  = wr_ptr_q;

endmodule

// File: rtl/rhs_sample_packetizer.sv
// Frames RHS channel words into MAGIC-headed samples and batches
// them into AXI-Stream packets for the DMA.
module rhs_sample_packetizer
  import rhs_pkt_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEFAULT,
  parameter int FIFO_DEPTH = 64,
  parameter logic [63:0] MAGIC = MAGIC_DEFAULT
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        enable,
  input  logic [7:0]  batch_size,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  input  logic        s_first,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [15:0] frames_dropped,
  output logic        frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(NUM_CH + 1);
  localparam logic [AW:0]   NCH_P   = (AW+1)'(NUM_CH);
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [CW-1:0] NCH_C   = CW'(NUM_CH);
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);
  localparam logic [CW-1:0] C_ONE   = 1;

  pkt_state_e state_q, state_d;
  logic          in_frame_q, in_frame_d;
  logic          admit_q, admit_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [AW:0]   start_ptr_q, start_ptr_d;
  logic [AW:0]   cmpl_q, cmpl_d;
  logic [15:0]   drop_q, drop_d;
  logic          err_q, err_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    batch_q, batch_d;
  logic [CW-1:0] chan_q, chan_d;
  logic          hold_q, hold_d;

  logic          f_wr_en, f_rd_en, f_rb_en;
  logic [AW:0]   f_wr_ptr, f_free;
  logic [31:0]   f_rd_data;
  logic          start, cmpl_inc, cmpl_dec, last_ch, more;

  rhs_pkt_fifo #(
    .DW    (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst     (areset),
    .wr_en   (f_wr_en),
    .wr_data (s_data),
    .rd_en   (f_rd_en),
    .rd_data (f_rd_data),
    .rb_en   (f_rb_en),
    .rb_ptr  (start_ptr_q),
    .wr_ptr  (f_wr_ptr),
    .free    (f_free)
  );

  assign start   = s_valid && s_first && enable;
  assign f_rb_en = start && in_frame_q && admit_q;

  always_comb begin
    in_frame_d  = in_frame_q;
    admit_d     = admit_q;
    wcnt_d      = wcnt_q;
    start_ptr_d = start_ptr_q;
    drop_d      = drop_q;
    err_d       = err_q;
    f_wr_en     = 1'b0;
    cmpl_inc    = 1'b0;
    if (start) begin
      if (in_frame_q) begin
        err_d = 1'b1;
      end
      in_frame_d  = 1'b1;
      wcnt_d      = C_ONE;
      start_ptr_d = f_rb_en ? start_ptr_q : f_wr_ptr;
      admit_d     = (f_free >= NCH_P);
      f_wr_en     = admit_d;
      if (!admit_d && drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end else if (s_valid && in_frame_q) begin
      f_wr_en = admit_q;
      wcnt_d  = wcnt_q + C_ONE;
    end
    if (in_frame_d && wcnt_d == NCH_C) begin
      in_frame_d = 1'b0;
      cmpl_inc   = admit_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    batch_d       = batch_q;
    chan_d        = chan_q;
    hold_d        = hold_q;
    cmpl_dec      = 1'b0;
    f_rd_en       = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    last_ch       = (chan_q == LAST_CH);
    more          = ({1'b0, idx_q} + 9'd1 < {1'b0, batch_q}) && enable;
    unique case (state_q)
      IDLE: begin
        if (cmpl_q != '0) begin
          state_d  = HDR_LO;
          cmpl_dec = 1'b1;
          idx_d    = '0;
          batch_d  = (batch_size == 8'd0) ? 8'd1 : batch_size;
        end
      end
      HDR_LO: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = MAGIC[31:0];
        if (m_axis_tready) state_d = HDR_HI;
      end
      HDR_HI: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = MAGIC[63:32];
        if (m_axis_tready) begin
          state_d = DATA;
          chan_d  = '0;
          hold_d  = 1'b0;
        end
      end
      DATA: begin
        // hold: mid-batch, waiting for the next frame to complete
        if (hold_q) begin
          if (!enable) begin
            state_d = IDLE;
            hold_d  = 1'b0;
          end else if (cmpl_q != '0) begin
            state_d  = HDR_LO;
            cmpl_dec = 1'b1;
            hold_d   = 1'b0;
          end
        end else begin
          m_axis_tvalid = 1'b1;
          m_axis_tdata  = f_rd_data;
          m_axis_tlast  = last_ch && !more;
          if (m_axis_tready) begin
            f_rd_en = 1'b1;
            chan_d  = chan_q + C_ONE;
            if (last_ch && more) begin
              idx_d = idx_q + 8'd1;
              if (cmpl_q != '0) begin
                state_d  = HDR_LO;
                cmpl_dec = 1'b1;
              end else begin
                hold_d = 1'b1;
              end
            end else if (last_ch) begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmpl_d = cmpl_q;
    if (cmpl_inc && !cmpl_dec) begin
      cmpl_d = cmpl_q + CNT_ONE;
    end else if (!cmpl_inc && cmpl_dec) begin
      cmpl_d = cmpl_q - CNT_ONE;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      in_frame_q  <= 1'b0;
      admit_q     <= 1'b0;
      wcnt_q      <= '0;
      start_ptr_q <= '0;
      cmpl_q      <= '0;
      drop_q      <= '0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      batch_q     <= '0;
      chan_q      <= '0;
      hold_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_frame_q  <= in_frame_d;
      admit_q     <= admit_d;
      wcnt_q      <= wcnt_d;
      start_ptr_q <= start_ptr_d;
      cmpl_q      <= cmpl_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      batch_q     <= batch_d;
      chan_q      <= chan_d;
      hold_q      <= hold_d;
    end
  end

  assign frames_dropped = drop_q;
  assign frame_err      = err_q;

endmodule

// File: tb/tb_rhs_sample_packetizer.sv
// Directed bench for rhs_sample_packetizer with a queue-based
// model of admission, sample framing and packet boundaries.
module tb_rhs_sample_packetizer;
  import rhs_pkt_pkg::*;

  localparam int NCH = NUM_CH_DEFAULT;
  localparam int DEPTH = 64;
  localparam int SW = HDR_WORDS + NCH;
  localparam logic [63:0] MG = MAGIC_DEFAULT;

  logic        aclk = 1'b0;
  logic        areset;
  logic        enable;
  logic [7:0]  batch_size;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_first;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [15:0] frames_dropped;
  logic        frame_err;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic        is_data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] cap_d[$];
  logic        cap_l[$];
  int          checks = 0;
  int          passes = 0;
  int          occ, drops, pkt_pos, batch_m;
  logic        exp_err;
  logic        rnd_ready = 1'b0;
  logic        ready_fix = 1'b1;
  logic        stall_v = 1'b0;
  logic [31:0] stall_d;
  logic        stall_l;

  rhs_sample_packetizer #(
    .NUM_CH     (NCH),
    .FIFO_DEPTH (DEPTH),
    .MAGIC      (MG)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .enable         (enable),
    .batch_size     (batch_size),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_first        (s_first),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .frames_dropped (frames_dropped),
    .frame_err      (frame_err)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic int n_last();
    int n = 0;
    foreach (cap_l[i]) n += int'(cap_l[i]);
    return n;
  endfunction

  task automatic push_exp(input logic [31:0] d, input logic l,
                          input logic isd);
    exp_t e;
    e.d = d;
    e.l = l;
    e.is_data = isd;
    exp_q.push_back(e);
  endtask

  // One sample: MAGIC low, MAGIC high, then channels 0..NCH-1.
  task automatic push_sample(input logic [31:0] base);
    logic last_s;
    last_s = (pkt_pos == batch_m - 1);
    push_exp(MG[31:0], 1'b0, 1'b0);
    push_exp(MG[63:32], 1'b0, 1'b0);
    for (int k = 0; k < NCH; k++)
      push_exp(base + k, last_s && (k == NCH - 1), 1'b1);
    pkt_pos = last_s ? 0 : pkt_pos + 1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  // nw < NCH models a frame cut short by the next s_first.
  task automatic send_frame(input logic [31:0] base, input int nw);
    logic adm;
    logic en;
    en  = enable;
    adm = en && ((DEPTH - occ) >= NCH);
    if (en) begin
      if (adm && nw == NCH) push_sample(base);
      if (!adm) drops++;
      if (nw < NCH) exp_err = 1'b1;
    end
    for (int k = 0; k < nw; k++) begin
      s_valid = 1'b1;
      s_first = (k == 0);
      s_data  = base + k;
      tick(1);
    end
    s_valid = 1'b0;
    s_first = 1'b0;
    if (adm && nw == NCH) occ += NCH;
  endtask

  task automatic model_clear(input int b);
    exp_q.delete();
    cap_d.delete();
    cap_l.delete();
    occ = 0;
    drops = 0;
    pkt_pos = 0;
    exp_err = 1'b0;
    batch_m = (b == 0) ? 1 : b;
  endtask

  task automatic do_reset(input int b);
    areset = 1'b1;
    batch_size = 8'(b);
    model_clear(b);
    tick(1);
    areset = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge aclk);
    chk({tag, "_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_tlast"}, m_axis_tlast, 0);
    chk({tag, "_tdata"}, m_axis_tdata, 0);
    chk({tag, "_dropped"}, frames_dropped, 0);
    chk({tag, "_err"}, frame_err, 0);
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_words(input int n, input int budget,
                            input string name);
    int c = 0;
    while (cap_d.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    chk(name, cap_d.size(), n);
  endtask

  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fix;
    end
  end

  always @(negedge aclk) begin
    exp_t e;
    if (areset) begin
      stall_v = 1'b0;
    end else begin
      if (stall_v) begin
        chk("stall_tvalid", m_axis_tvalid, 1);
        chk("stall_tdata", m_axis_tdata, stall_d);
        chk("stall_tlast", m_axis_tlast, stall_l);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        cap_d.push_back(m_axis_tdata);
        cap_l.push_back(m_axis_tlast);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_word: got %h last=%b, expected none",
                   m_axis_tdata, m_axis_tlast);
        end else begin
          e = exp_q.pop_front();
          chk("stream_tdata", m_axis_tdata, e.d);
          chk("stream_tlast", m_axis_tlast, e.l);
          if (e.is_data) occ--;
        end
      end
      stall_v = m_axis_tvalid && !m_axis_tready;
      stall_d = m_axis_tdata;
      stall_l = m_axis_tlast;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    enable = 1'b1;
    batch_size = 8'd2;
    s_data = '0;
    s_valid = 1'b0;
    s_first = 1'b0;
    model_clear(2);
    tick(2);

    // Reset state
    do_reset(2);
    check_idle_outputs("reset");

    // Case 1: basic two-sample packet
    do_reset(2);
    send_frame(32'h100, NCH);
    send_frame(32'h120, NCH);
    wait_words(2 * SW, 300, "c1_count");
    if (cap_d.size() >= 2 * SW) begin
      chk("c1_word0", cap_d[0], 32'h38132A53);
      chk("c1_word1", cap_d[1], 32'hD7A22AAA);
      chk("c1_word2", cap_d[2], 32'h100);
      chk("c1_word67", cap_d[67], 32'h13F);
      chk("c1_last67", cap_l[67], 1);
    end
    chk("c1_nlast", n_last(), 1);
    chk("c1_drained", exp_q.size(), 0);

    // Case 2: same traffic under random backpressure
    do_reset(2);
    rnd_ready = 1'b1;
    send_frame(32'h100, NCH);
    send_frame(32'h120, NCH);
    wait_words(2 * SW, 800, "c2_count");
    rnd_ready = 1'b0;
    if (cap_d.size() >= 2 * SW) begin
      chk("c2_word67", cap_d[67], 32'h13F);
      chk("c2_last67", cap_l[67], 1);
    end
    chk("c2_nlast", n_last(), 1);
    chk("c2_drained", exp_q.size(), 0);

    // Case 3: overflow while the sink is stalled
    ready_fix = 1'b0;
    do_reset(2);
    send_frame(32'h100, NCH);
    send_frame(32'h120, NCH);
    send_frame(32'h140, NCH);
    tick(2);
    chk("c3_dropped_model", frames_dropped, drops);
    chk("c3_dropped", frames_dropped, 1);
    ready_fix = 1'b1;
    wait_words(2 * SW, 300, "c3_count");
    tick(50);
    chk("c3_no_extra", cap_d.size(), 2 * SW);
    if (cap_d.size() >= 2 * SW) begin
      chk("c3_word67", cap_d[67], 32'h13F);
      chk("c3_last67", cap_l[67], 1);
    end
    chk("c3_drained", exp_q.size(), 0);

    // Case 4: s_first arrives at word 10 of a frame
    do_reset(1);
    send_frame(32'h300, 10);
    send_frame(32'h400, NCH);
    wait_words(SW, 200, "c4_count");
    chk("c4_err_model", frame_err, exp_err);
    chk("c4_err", frame_err, 1);
    if (cap_d.size() >= SW) begin
      chk("c4_word2", cap_d[2], 32'h400);
      chk("c4_last", cap_l[SW-1], 1);
    end
    chk("c4_drained", exp_q.size(), 0);

    // Case 5: disable during the third sample of an 8-sample batch
    do_reset(8);
    send_frame(32'h500, NCH);
    tick(40);
    send_frame(32'h520, NCH);
    tick(40);
    send_frame(32'h540, NCH);
    tick(5);
    enable = 1'b0;
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].l = 1'b1;
    send_frame(32'h560, NCH);
    wait_words(3 * SW, 400, "c5_count");
    tick(60);
    chk("c5_no_more", cap_d.size(), 3 * SW);
    if (cap_d.size() >= 3 * SW) chk("c5_last", cap_l[3*SW-1], 1);
    chk("c5_nlast", n_last(), 1);
    chk("c5_drained", exp_q.size(), 0);
    enable = 1'b1;

    // Case 6: reset while data word 5 is on the bus
    do_reset(1);
    send_frame(32'h600, NCH);
    wait_words(HDR_WORDS + 5, 100, "c6_pre");
    do_reset(1);
    check_idle_outputs("c6_reset");
    send_frame(32'h700, NCH);
    wait_words(SW, 200, "c6_count");
    if (cap_d.size() >= SW) begin
      chk("c6_word0", cap_d[0], 32'h38132A53);
      chk("c6_word2", cap_d[2], 32'h700);
      chk("c6_last", cap_l[SW-1], 1);
    end
    chk("c6_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
